// File: rtl/spi_master_shifter.sv
// SPI mode-0 master serializer/deserializer.
// Accepts a rising edge of go_transfer while idle, shifts one full-duplex frame
// of DATA_WIDTH bits with an SCLK half-period of CLK_DIV clk cycles, then
// returns the captured word and drops data_pack_ready to mark it valid.
// Optional build macro: SPI_LSB_FIRST_EN selects LSB-first shifting in both
// directions; when undefined the frame is MSB-first.
module spi_master_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go_transfer,
    input  logic [DATA_WIDTH-1:0] data_write_to_spi,
    output logic [DATA_WIDTH-1:0] data_read_from_spi,
    output logic                  data_pack_ready,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    input  logic                  spi_miso,
    output logic                  spi_cs_n
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CS_SETUP = 3'd1,
        SHIFT    = 3'd2,
        CS_HOLD  = 3'd3,
        GAP      = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic                    go_d_r;
    logic [CNT_W-1:0]        div_cnt_r, div_cnt_s;
    logic [BIT_W-1:0]        bit_cnt_r, bit_cnt_s;
    logic [DATA_WIDTH-1:0]   tx_shift_r, tx_shift_s;
    logic [DATA_WIDTH-1:0]   rx_shift_r, rx_shift_s;
    logic [DATA_WIDTH-1:0]   rd_data_r, rd_data_s;
    logic                    dpr_r, dpr_s;
    logic                    sclk_r, sclk_s;
    logic                    cs_n_r, cs_n_s;
    logic                    start_s;
    logic                    tc_s;

    // Move the transmit register on by one bit; the outgoing bit sits at the
    // end that drives MOSI, and vacated positions fill with zero.
    function automatic logic [DATA_WIDTH-1:0] tx_advance(input logic [DATA_WIDTH-1:0] v);
`ifdef SPI_LSB_FIRST_EN
        return {1'b0, v[DATA_WIDTH-1:1]};
`else
        return {v[DATA_WIDTH-2:0], 1'b0};
`endif
    endfunction

    // Insert one sampled MISO bit so the first received bit ends at the same
    // significance the first transmitted bit came from.
    function automatic logic [DATA_WIDTH-1:0] rx_insert(input logic [DATA_WIDTH-1:0] v,
                                                        input logic b);
`ifdef SPI_LSB_FIRST_EN
        return {b, v[DATA_WIDTH-1:1]};
`else
        return {v[DATA_WIDTH-2:0], b};
`endif
    endfunction

    assign start_s = (state_r == IDLE) && go_transfer && !go_d_r;
    assign tc_s    = (div_cnt_r == DIV_LAST);

    // MOSI is taken straight from the shift register so it is always a flop output.
`ifdef SPI_LSB_FIRST_EN
    assign spi_mosi = tx_shift_r[0];
`else
    assign spi_mosi = tx_shift_r[DATA_WIDTH-1];
`endif

    assign data_read_from_spi = rd_data_r;
    assign data_pack_ready    = dpr_r;
    assign spi_sclk           = sclk_r;
    assign spi_cs_n           = cs_n_r;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_s    = state_r;
        bit_cnt_s  = bit_cnt_r;
        tx_shift_s = tx_shift_r;
        rx_shift_s = rx_shift_r;
        rd_data_s  = rd_data_r;
        dpr_s      = dpr_r;
        sclk_s     = sclk_r;
        cs_n_s     = cs_n_r;

        // One shared divider paces CS setup, every SCLK half-period, CS hold and the gap.
        if (state_r == IDLE) begin
            div_cnt_s = '0;
        end else if (tc_s) begin
            div_cnt_s = '0;
        end else begin
            div_cnt_s = div_cnt_r + CNT_W'(1'b1);
        end

        case (state_r)
            IDLE: begin
                if (start_s) begin
                    tx_shift_s = data_write_to_spi;
                    rx_shift_s = '0;
                    bit_cnt_s  = '0;
                    sclk_s     = 1'b0;
                    cs_n_s     = 1'b0;
                    dpr_s      = 1'b1;
                    state_s    = CS_SETUP;
                end else begin
                    state_s    = IDLE;
                end
            end
            CS_SETUP: begin
                // End of CS setup coincides with the first SCLK rise.
                if (tc_s) begin
                    sclk_s     = 1'b1;
                    rx_shift_s = rx_insert(rx_shift_r, spi_miso);
                    state_s    = SHIFT;
                end else begin
                    state_s    = CS_SETUP;
                end
            end
            SHIFT: begin
                if (!tc_s) begin
                    state_s = SHIFT;
                end else if (!sclk_r) begin
                    sclk_s     = 1'b1;
                    rx_shift_s = rx_insert(rx_shift_r, spi_miso);
                end else begin
                    sclk_s = 1'b0;
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_s = '0;
                        state_s   = CS_HOLD;
                    end else begin
                        bit_cnt_s  = bit_cnt_r + BIT_W'(1'b1);
                        tx_shift_s = tx_advance(tx_shift_r);
                    end
                end
            end
            CS_HOLD: begin
                if (tc_s) begin
                    cs_n_s     = 1'b1;
                    tx_shift_s = '0;
                    rd_data_s  = rx_shift_r;
                    dpr_s      = 1'b0;
                    state_s    = GAP;
                end else begin
                    state_s    = CS_HOLD;
                end
            end
            GAP: begin
                if (tc_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = GAP;
                end
            end
            default: begin
                state_s    = IDLE;
                bit_cnt_s  = '0;
                tx_shift_s = '0;
                sclk_s     = 1'b0;
                cs_n_s     = 1'b1;
                dpr_s      = 1'b0;
            end
        endcase
    end

    // State and output registers; reset returns the bus to idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            go_d_r     <= 1'b0;
            div_cnt_r  <= '0;
            bit_cnt_r  <= '0;
            tx_shift_r <= '0;
            rx_shift_r <= '0;
            rd_data_r  <= '0;
            dpr_r      <= 1'b0;
            sclk_r     <= 1'b0;
            cs_n_r     <= 1'b1;
        end else begin
            state_r    <= state_s;
            go_d_r     <= go_transfer;
            div_cnt_r  <= div_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            tx_shift_r <= tx_shift_s;
            rx_shift_r <= rx_shift_s;
            rd_data_r  <= rd_data_s;
            dpr_r      <= dpr_s;
            sclk_r     <= sclk_s;
            cs_n_r     <= cs_n_s;
        end
    end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Self-checking bench for spi_master_shifter (DATA_WIDTH=32, CLK_DIV=4).
// Expected read words are queued when a frame is requested and compared when
// data_pack_ready falls; frame timing is measured against the CS falling edge.
module tb_spi_master_shifter;

    logic        clk;
    logic        reset;
    logic        go_transfer;
    logic [31:0] data_write_to_spi;
    logic [31:0] data_read_from_spi;
    logic        data_pack_ready;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs_n;

    logic        loop_en;
    logic        miso_c;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          e0 = 0;
    int          rises = 0;
    int          first_rise_cyc = 0;
    logic        first_bit = 1'b0;
    int          mosi_hi = 0;
    int          last_mosi_hi = 0;
    logic        last_first_bit = 1'b0;
    int          cs_falls = 0;
    int          frames_done = 0;
    logic [31:0] exp_q[$];

    assign spi_miso = loop_en ? spi_mosi : miso_c;

    spi_master_shifter #(
        .DATA_WIDTH(32),
        .CLK_DIV   (4)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .go_transfer       (go_transfer),
        .data_write_to_spi (data_write_to_spi),
        .data_read_from_spi(data_read_from_spi),
        .data_pack_ready   (data_pack_ready),
        .spi_sclk          (spi_sclk),
        .spi_mosi          (spi_mosi),
        .spi_miso          (spi_miso),
        .spi_cs_n          (spi_cs_n)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter advanced on every active edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bus monitor: frame timing and scoreboard comparison on each completion.
    initial begin
        logic p_cs, p_sclk, p_dpr;
        p_cs = 1'b1; p_sclk = 1'b0; p_dpr = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                p_cs = 1'b1; p_sclk = 1'b0; p_dpr = 1'b0;
            end else begin
                if (p_cs && !spi_cs_n) begin
                    cs_falls = cs_falls + 1;
                    e0 = cyc;
                    rises = 0;
                    mosi_hi = 0;
                end
                if (!spi_cs_n && spi_mosi) mosi_hi = mosi_hi + 1;
                if (!p_sclk && spi_sclk) begin
                    if (rises == 0) begin
                        first_rise_cyc = cyc;
                        first_bit = spi_mosi;
                    end
                    rises = rises + 1;
                end
                if (p_dpr && !data_pack_ready) begin
                    check_eq("frame_len", cyc - e0, 260);
                    check_eq("first_rise", first_rise_cyc - e0, 4);
                    check_eq("sclk_rises", rises, 32);
                    check_eq("cs_n_end", {31'd0, spi_cs_n}, 32'd1);
                    check_eq("mosi_end", {31'd0, spi_mosi}, 32'd0);
                    check_eq("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
                    if (exp_q.size() > 0) check_eq("read_data", data_read_from_spi, exp_q.pop_front());
                    last_mosi_hi = mosi_hi;
                    last_first_bit = first_bit;
                    frames_done = frames_done + 1;
                end
                p_cs = spi_cs_n; p_sclk = spi_sclk; p_dpr = data_pack_ready;
            end
        end
    end

    // Hard stop if the run ever stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic start_frame(input logic [31:0] d, input logic [31:0] exp);
        @(negedge clk);
        data_write_to_spi = d;
        go_transfer = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        go_transfer = 1'b0;
        data_write_to_spi = $urandom();
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_done < target && n < 2000) begin
            @(negedge clk);
            n = n + 1;
        end
        check_eq("frame_done", frames_done, target);
        repeat (10) @(negedge clk);
    endtask

    task automatic wait_e0_plus(input int k);
        int n = 0;
        @(negedge clk);
        while (cyc < e0 + k && n < 1000) begin
            @(negedge clk);
            n = n + 1;
        end
    endtask

    initial begin
        int base_f;
        int base_c;
        reset = 1'b1;
        go_transfer = 1'b0;
        data_write_to_spi = 32'h0;
        loop_en = 1'b1;
        miso_c = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check_eq("rst_sclk", {31'd0, spi_sclk}, 32'd0);
        check_eq("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check_eq("rst_dpr", {31'd0, data_pack_ready}, 32'd0);
        check_eq("rst_read", data_read_from_spi, 32'h0000_0000);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Loopback frame; data input is scrambled right after acceptance.
        loop_en = 1'b1;
        start_frame(32'hA5C3_0F96, 32'hA5C3_0F96);
        wait_frames(1);
        check_eq("read_stable", data_read_from_spi, 32'hA5C3_0F96);

        // Constant MISO levels.
        loop_en = 1'b0;
        miso_c = 1'b1;
        start_frame(32'h0000_0000, 32'hFFFF_FFFF);
        wait_frames(2);
        check_eq("mosi_low_all", last_mosi_hi, 0);
        miso_c = 1'b0;
        start_frame(32'hFFFF_FFFF, 32'h0000_0000);
        wait_frames(3);

        // Second go pulse mid-frame is ignored.
        loop_en = 1'b1;
        base_c = cs_falls;
        start_frame(32'h3C3C_55AA, 32'h3C3C_55AA);
        wait_e0_plus(100);
        go_transfer = 1'b1;
        @(negedge clk);
        go_transfer = 1'b0;
        wait_frames(4);
        repeat (300) @(negedge clk);
        check_eq("busy_cs_falls", cs_falls - base_c, 1);
        check_eq("busy_frames", frames_done, 4);

        // go held high for 600 cycles yields exactly one frame.
        base_c = cs_falls;
        @(negedge clk);
        data_write_to_spi = 32'h0F0F_1234;
        go_transfer = 1'b1;
        exp_q.push_back(32'h0F0F_1234);
        repeat (600) @(negedge clk);
        go_transfer = 1'b0;
        wait_frames(5);
        check_eq("held_cs_falls", cs_falls - base_c, 1);

        // Asynchronous reset in the middle of a frame.
        base_f = frames_done;
        start_frame(32'hDEAD_BEEF, 32'hDEAD_BEEF);
        wait_e0_plus(130);
        #2;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
        check_eq("mid_rst_sclk", {31'd0, spi_sclk}, 32'd0);
        check_eq("mid_rst_dpr", {31'd0, data_pack_ready}, 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_eq("mid_rst_read", data_read_from_spi, 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mid_rst_no_frame", frames_done, base_f);
        start_frame(32'h1234_5678, 32'h1234_5678);
        wait_frames(base_f + 1);

        // Single set bit shows shift order on MOSI.
        start_frame(32'h0000_0001, 32'h0000_0001);
        wait_frames(base_f + 2);
`ifdef SPI_LSB_FIRST_EN
        check_eq("first_bit", {31'd0, last_first_bit}, 32'd1);
        check_eq("one_bit_len", last_mosi_hi, 8);
`else
        check_eq("first_bit", {31'd0, last_first_bit}, 32'd0);
        check_eq("one_bit_len", last_mosi_hi, 12);
`endif

        check_eq("sb_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_master_shifter.md
Name: spi_master_shifter

Overview:
- SPI master serializer/deserializer directly downstream of the Avalon slave register block.
- Consumes the slave's go_transfer pulse and data_write_to_spi word, and runs one full-duplex SPI mode-0 frame.
- Returns the captured word on data_read_from_spi and signals completion with a falling edge on data_pack_ready.
- The slave's 2-flop edge detector consumes that falling edge as transfer_complete.

Parameters:
- DATA_WIDTH, 32, frame length in bits; must be ≥ 2.
- CLK_DIV, 4, SCLK half-period in clk cycles; must be ≥ 2. Also sets the CS setup, CS hold and inter-frame gap lengths.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- go_transfer  input  1  start request. Only its rising edge is acted on, and only in IDLE.
- data_write_to_spi  input  DATA_WIDTH  word to transmit, latched on the accept cycle.
- data_read_from_spi  output  DATA_WIDTH  received word, updated at frame end.
- data_pack_ready  output  1  high while a frame is in progress. The falling edge marks data_read_from_spi as valid.
- spi_sclk  output  1  serial clock, idles low (CPOL=0).
- spi_mosi  output  1  serial data out.
- spi_miso  input  1  serial data in.
- spi_cs_n  output  1  active-low slave select.

Behaviour:
- Reset values (asynchronous, applied immediately, including mid-frame):
  - spi_cs_n=1, spi_sclk=0, spi_mosi=0, data_pack_ready=0.
  - data_read_from_spi=0; all counters 0; state IDLE.
- Start detect: go_d registers go_transfer. A start is accepted when the state is IDLE and go_transfer=1 and go_d=0. That clock edge is E0.
- Accept at E0:
  - tx_shift <= data_write_to_spi; rx_shift cleared.
  - spi_cs_n <= 0; spi_mosi <= data_write_to_spi[DATA_WIDTH-1].
  - data_pack_ready <= 1; state <= CS_SETUP.
- States and transitions:
  - IDLE → CS_SETUP on an accepted start.
  - CS_SETUP: waits CLK_DIV cycles, then → SHIFT.
  - SHIFT: div_cnt counts 0..CLK_DIV-1; spi_sclk toggles at terminal count.
    - Toggle k (k=1..2*DATA_WIDTH) occurs at E0 + k*CLK_DIV.
    - Rising toggle: rx_shift <= {rx_shift[DATA_WIDTH-2:0], spi_miso}.
    - Falling toggle: bit_cnt increments. If it was DATA_WIDTH-1, → CS_HOLD with sclk low and mosi unchanged; otherwise spi_mosi <= next bit (tx_shift shifts left).
  - CS_HOLD: waits CLK_DIV cycles. At E0 + (2*DATA_WIDTH+1)*CLK_DIV, in the same cycle: spi_cs_n <= 1, spi_mosi <= 0, data_read_from_spi <= rx_shift, data_pack_ready <= 0. Then → GAP.
  - GAP: holds spi_cs_n high for CLK_DIV cycles, then → IDLE.
- Data read timing: data_read_from_spi stays stable until the next frame completes.
- Defaults (CLK_DIV=4, W=32): first sclk rise at E0+4, last fall at E0+256, data_pack_ready falls at E0+260, next start accepted no earlier than E0+264.
- MOSI is stable for the full CLK_DIV cycles before each sclk rise. MISO is sampled in the cycle the sclk rise is issued.
- Rising edges of go_transfer outside IDLE are ignored and not queued. go_transfer held high yields exactly one frame.
- go_d tracks go_transfer in every state. A go that rises during GAP and stays high does not start a frame.
- data_write_to_spi changes after E0 have no effect on the current frame.

Optional Feature:
- SPI_LSB_FIRST_EN defined:
  - First mosi bit is data_write_to_spi[0]; tx_shift shifts right.
  - Received bits enter at rx_shift[DATA_WIDTH-1] and shift right, so the first received bit ends at bit 0.
  - Timing is identical to MSB-first.
- Not defined: MSB-first as described in Behaviour.

Test Plan:
- Reset check: hold reset 3 cycles → cs_n=1, sclk=0, mosi=0, data_pack_ready=0, data_read_from_spi=0x00000000.
- Loopback: miso tied to mosi, go pulse with data 0xA5C30F96 → exactly 32 sclk rises; cs_n low from E0 to E0+260; data_pack_ready falls at E0+260; data_read_from_spi=0xA5C30F96.
- Constant input: miso=1 with data 0x00000000 → mosi low all frame, read 0xFFFFFFFF. Then miso=0 with data 0xFFFFFFFF → read 0x00000000.
- Busy ignore: second go pulse at E0+100, plus a separate go held high for 600 cycles → only one frame per accepted edge; cs_n falls exactly once per edge.
- Mid-frame reset: reset pulse at E0+130 → cs_n=1, sclk=0, data_pack_ready=0 asynchronously. A new go afterwards with data 0x12345678 in loopback completes normally with read 0x12345678.
- SPI_LSB_FIRST_EN defined, data 0x00000001 in loopback → mosi=1 during the first bit only; read 0x00000001.
